// File: rtl/fp_wb_pkg.sv
// Shared types for the FP register-file writeback path.
package fp_wb_pkg;

    localparam int unsigned FP_NUM_REGS = 32;
    localparam int unsigned FP_REG_W    = $clog2(FP_NUM_REGS);
    localparam int unsigned FP_XLEN     = 32;

    // Accrued exception flags, in fflags CSR bit order.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Rounding modes; 5 and 6 are reserved, 7 is only meaningful in an instruction.
    typedef enum logic [2:0] {
        FRM_RNE = 3'd0,
        FRM_RTZ = 3'd1,
        FRM_RDN = 3'd2,
        FRM_RUP = 3'd3,
        FRM_RMM = 3'd4,
        FRM_DYN = 3'd7
    } frm_t;

    // One queued FPU result.
    typedef struct packed {
        logic [FP_REG_W-1:0] rd;
        logic [FP_XLEN-1:0]  data;
    } wb_entry_t;

    // A stored frm that is not a usable static rounding mode.
    function automatic logic frm_is_invalid(input logic [2:0] v);
        return (v >= 3'd5);
    endfunction

endpackage

// File: rtl/f_wb_fifo.sv
// Small FIFO of pending FPU results; exposes per-entry rd/valid for hazard lookup.
module f_wb_fifo
    import fp_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               i_push,
    input  wb_entry_t                          i_push_entry,
    input  logic                               i_pop,
    output wb_entry_t                          o_head,
    output logic                               o_full,
    output logic                               o_empty,
    output logic [DEPTH-1:0]                   o_ent_valid,
    output logic [DEPTH-1:0][FP_REG_W-1:0]     o_ent_rd
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_ent_valid = r_valid;

    // Flatten stored rd fields for the query comparator.
    always_comb begin
        o_ent_rd = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            o_ent_rd[i] = r_mem[i].rd;
        end
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr]   <= i_push_entry;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/f_writeback_arbiter.sv
// Single FP register-file write port shared by loads and FPU results, plus fflags/frm CSRs.
module f_writeback_arbiter
    import fp_wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned NUM_REGS   = FP_NUM_REGS,
    localparam int unsigned REG_W     = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             fpu_valid,
    output logic             fpu_ready,
    input  logic [REG_W-1:0] fpu_rd,
    input  logic [31:0]      fpu_result,
    input  logic [4:0]       fpu_flags,
    input  logic             ld_valid,
    input  logic [REG_W-1:0] ld_rd,
    input  logic [31:0]      ld_data,
    output logic             f_wen,
    output logic [REG_W-1:0] f_rd,
    output logic [31:0]      f_w_data,
    input  logic             csr_flags_wen,
    input  logic [4:0]       csr_flags_wdata,
    input  logic             csr_frm_wen,
    input  logic [2:0]       csr_frm_wdata,
    output logic [4:0]       fflags,
    output logic [2:0]       frm,
    output logic             frm_invalid,
    input  logic [REG_W-1:0] query_rd,
    output logic             query_busy
);

    logic                                w_full;
    logic                                w_empty;
    logic                                w_accept;
    logic                                w_bypass;
    logic                                w_push;
    logic                                w_pop;
    wb_entry_t                           w_head;
    wb_entry_t                           w_fpu_entry;
    logic [FIFO_DEPTH-1:0]               w_ent_valid;
    logic [FIFO_DEPTH-1:0][FP_REG_W-1:0] w_ent_rd;
    logic [4:0]                          w_fflags_nxt;
    logic                                r_wen;
    logic [REG_W-1:0]                    r_rd;
    logic [31:0]                         r_data;
    fflags_t                             r_fflags;
    logic [2:0]                          r_frm;
    logic                                r_frm_invalid;

    // Ready is purely !full: a same-cycle pop never frees a slot for a push.
    assign fpu_ready = ~w_full;
    assign w_accept  = fpu_valid & fpu_ready;
    assign w_bypass  = w_accept & ~ld_valid & w_empty;
    assign w_push    = w_accept & ~w_bypass;
    assign w_pop     = ~ld_valid & ~w_empty;

    assign w_fpu_entry.rd   = FP_REG_W'(fpu_rd);
    assign w_fpu_entry.data = fpu_result;

    f_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .n_rst        (n_rst),
        .i_push       (w_push),
        .i_push_entry (w_fpu_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_ent_valid  (w_ent_valid),
        .o_ent_rd     (w_ent_rd)
    );

    // Output write register: load, then FIFO head, then bypassed FPU result.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wen  <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else if (ld_valid) begin
            r_wen  <= 1'b1;
            r_rd   <= ld_rd;
            r_data <= ld_data;
        end else if (!w_empty) begin
            r_wen  <= 1'b1;
            r_rd   <= REG_W'(w_head.rd);
            r_data <= w_head.data;
        end else if (w_bypass) begin
            r_wen  <= 1'b1;
            r_rd   <= fpu_rd;
            r_data <= fpu_result;
        end else begin
            r_wen  <= 1'b0;
        end
    end

    // Sticky flags: a software write replaces the base, accepted flags always OR in.
    assign w_fflags_nxt = (csr_flags_wen ? csr_flags_wdata : 5'(r_fflags))
                        | (w_accept ? fpu_flags : 5'b0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_fflags <= '0;
        end else begin
            r_fflags <= fflags_t'(w_fflags_nxt);
        end
    end

    // Rounding mode; reserved encodings are stored and flagged, not rejected.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_frm         <= FRM_RNE;
            r_frm_invalid <= 1'b0;
        end else if (csr_frm_wen) begin
            r_frm         <= csr_frm_wdata;
            r_frm_invalid <= frm_is_invalid(csr_frm_wdata);
        end
    end

    // Decode hazard: rd is busy until its value has actually been written.
    always_comb begin
        query_busy = r_wen & (r_rd == query_rd);
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (w_ent_valid[i] && (w_ent_rd[i] == FP_REG_W'(query_rd))) begin
                query_busy = 1'b1;
            end
        end
    end

    assign f_wen       = r_wen;
    assign f_rd        = r_rd;
    assign f_w_data    = r_data;
    assign fflags      = r_fflags;
    assign frm         = r_frm;
    assign frm_invalid = r_frm_invalid;

endmodule

// File: tb/tb_f_writeback_arbiter.sv
// Directed bench for the FP writeback arbiter.
module tb_f_writeback_arbiter;

    localparam int unsigned REG_W = 5;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             fpu_valid;
    logic             fpu_ready;
    logic [REG_W-1:0] fpu_rd;
    logic [31:0]      fpu_result;
    logic [4:0]       fpu_flags;
    logic             ld_valid;
    logic [REG_W-1:0] ld_rd;
    logic [31:0]      ld_data;
    logic             f_wen;
    logic [REG_W-1:0] f_rd;
    logic [31:0]      f_w_data;
    logic             csr_flags_wen;
    logic [4:0]       csr_flags_wdata;
    logic             csr_frm_wen;
    logic [2:0]       csr_frm_wdata;
    logic [4:0]       fflags;
    logic [2:0]       frm;
    logic             frm_invalid;
    logic [REG_W-1:0] query_rd;
    logic             query_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    f_writeback_arbiter #(
        .FIFO_DEPTH (2),
        .NUM_REGS   (32)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .fpu_valid       (fpu_valid),
        .fpu_ready       (fpu_ready),
        .fpu_rd          (fpu_rd),
        .fpu_result      (fpu_result),
        .fpu_flags       (fpu_flags),
        .ld_valid        (ld_valid),
        .ld_rd           (ld_rd),
        .ld_data         (ld_data),
        .f_wen           (f_wen),
        .f_rd            (f_rd),
        .f_w_data        (f_w_data),
        .csr_flags_wen   (csr_flags_wen),
        .csr_flags_wdata (csr_flags_wdata),
        .csr_frm_wen     (csr_frm_wen),
        .csr_frm_wdata   (csr_frm_wdata),
        .fflags          (fflags),
        .frm             (frm),
        .frm_invalid     (frm_invalid),
        .query_rd        (query_rd),
        .query_busy      (query_busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fpu_valid       = 1'b0;
        fpu_rd          = '0;
        fpu_result      = '0;
        fpu_flags       = '0;
        ld_valid        = 1'b0;
        ld_rd           = '0;
        ld_data         = '0;
        csr_flags_wen   = 1'b0;
        csr_flags_wdata = '0;
        csr_frm_wen     = 1'b0;
        csr_frm_wdata   = '0;
    endtask

    task automatic check_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
        check({tag, "_wen"},  32'(f_wen), 32'd1);
        check({tag, "_rd"},   32'(f_rd), 32'(rd));
        check({tag, "_data"}, f_w_data, data);
    endtask

    initial begin
        idle_inputs();
        query_rd = 5'd9;

        // Reset held while the FPU presents a result.
        n_rst      = 1'b0;
        fpu_valid  = 1'b1;
        fpu_rd     = 5'd9;
        fpu_result = 32'h1234_5678;
        fpu_flags  = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_wen",   32'(f_wen), 32'd0);
            check("rst_fflags", 32'(fflags), 32'd0);
            check("rst_frm",   32'(frm), 32'd0);
            check("rst_ready", 32'(fpu_ready), 32'd1);
            check("rst_busy",  32'(query_busy), 32'd0);
        end
        check("rst_rd",   32'(f_rd), 32'd0);
        check("rst_data", f_w_data, 32'd0);
        idle_inputs();
        n_rst = 1'b1;
        tick();
        check("post_rst_wen", 32'(f_wen), 32'd0);

        // Bypass into an empty FIFO, then hold on idle.
        fpu_valid  = 1'b1;
        fpu_rd     = 5'd3;
        fpu_result = 32'h3F80_0000;
        tick();
        check_wr("bypass", 5'd3, 32'h3F80_0000);
        idle_inputs();
        tick();
        check("idle_wen",  32'(f_wen), 32'd0);
        check("idle_rd",   32'(f_rd), 32'd3);
        check("idle_data", f_w_data, 32'h3F80_0000);

        // Load and FPU collide; FPU result queues behind the load.
        ld_valid   = 1'b1;
        ld_rd      = 5'd5;
        ld_data    = 32'hDEAD_BEEF;
        fpu_valid  = 1'b1;
        fpu_rd     = 5'd6;
        fpu_result = 32'h4000_0000;
        query_rd   = 5'd6;
        tick();
        check_wr("coll_ld", 5'd5, 32'hDEAD_BEEF);
        check("coll_busy1", 32'(query_busy), 32'd1);
        check("coll_ready", 32'(fpu_ready), 32'd1);
        idle_inputs();
        #1;
        check("coll_busy1b", 32'(query_busy), 32'd1);
        tick();
        check_wr("coll_fpu", 5'd6, 32'h4000_0000);
        check("coll_busy2", 32'(query_busy), 32'd1);
        tick();
        check("coll_done_wen", 32'(f_wen), 32'd0);
        check("coll_busy3",    32'(query_busy), 32'd0);

        // Backpressure: four loads, FPU offering a result every cycle.
        ld_valid  = 1'b1;
        fpu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_rd      = 5'(20 + i);
            ld_data    = 32'h1000 + 32'(i);
            fpu_rd     = (i < 2) ? 5'(12 + i) : 5'd14;
            fpu_result = (i < 2) ? 32'hA0 + 32'(i) : 32'hA2;
            tick();
            check_wr("bp_ld", 5'(20 + i), 32'h1000 + 32'(i));
            check("bp_ready", 32'(fpu_ready), (i == 0) ? 32'd1 : 32'd0);
        end
        idle_inputs();
        tick();
        check_wr("bp_drain0", 5'd12, 32'hA0);
        check("bp_ready_d0", 32'(fpu_ready), 32'd1);
        tick();
        check_wr("bp_drain1", 5'd13, 32'hA1);
        tick();
        check("bp_empty_wen", 32'(f_wen), 32'd0);

        // Sticky flags accumulate; a software write replaces but still merges accepted flags.
        fpu_valid = 1'b1;
        fpu_rd    = 5'd1;
        fpu_flags = 5'b00001;
        tick();
        check("flags_nx", 32'(fflags), 32'b00001);
        fpu_rd    = 5'd2;
        fpu_flags = 5'b10000;
        tick();
        check("flags_acc", 32'(fflags), 32'b10001);
        csr_flags_wen   = 1'b1;
        csr_flags_wdata = 5'b00000;
        fpu_flags       = 5'b00100;
        tick();
        check("flags_csr_merge", 32'(fflags), 32'b00100);
        idle_inputs();
        tick();
        check("flags_hold", 32'(fflags), 32'b00100);

        // Rounding mode storage and reserved-encoding flag.
        csr_frm_wen   = 1'b1;
        csr_frm_wdata = 3'd6;
        tick();
        check("frm6",     32'(frm), 32'd6);
        check("frm6_inv", 32'(frm_invalid), 32'd1);
        csr_frm_wdata = 3'd1;
        tick();
        check("frm1",     32'(frm), 32'd1);
        check("frm1_inv", 32'(frm_invalid), 32'd0);
        csr_frm_wdata = 3'd7;
        tick();
        check("frm7_inv", 32'(frm_invalid), 32'd1);
        idle_inputs();
        tick();
        check("frm_hold", 32'(frm), 32'd7);

        // Fill the FIFO behind loads, start draining, then reset asynchronously.
        ld_valid   = 1'b1;
        ld_rd      = 5'd25;
        ld_data    = 32'h55;
        fpu_valid  = 1'b1;
        fpu_rd     = 5'd10;
        fpu_result = 32'h10;
        tick();
        fpu_rd     = 5'd11;
        fpu_result = 32'h11;
        tick();
        check("fill_ready", 32'(fpu_ready), 32'd0);
        idle_inputs();
        query_rd = 5'd11;
        tick();
        check_wr("drain_first", 5'd10, 32'h10);
        check("drain_busy", 32'(query_busy), 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_wen",    32'(f_wen), 32'd0);
        check("arst_rd",     32'(f_rd), 32'd0);
        check("arst_busy",   32'(query_busy), 32'd0);
        check("arst_ready",  32'(fpu_ready), 32'd1);
        check("arst_fflags", 32'(fflags), 32'd0);
        check("arst_frm",    32'(frm), 32'd0);
        check("arst_frminv", 32'(frm_invalid), 32'd0);
        n_rst = 1'b1;
        tick();
        check("arst_nowrite0", 32'(f_wen), 32'd0);
        tick();
        check("arst_nowrite1", 32'(f_wen), 32'd0);
        check("arst_busy_end", 32'(query_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
